// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C write-only slave
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic       I2C_RW_WRITE  = 1'b0;
    localparam int         I2C_BYTE_BITS = 8;
    localparam logic [2:0] LAST_BIT      = 3'(I2C_BYTE_BITS - 1);

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - bus line synchronizer with registered level and edge pulses
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   synced;

    assign synced = chain[SYNC_STAGES-1];

    // Reset to 1 so an idle (pulled-up) bus produces no edges after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            level <= synced;
            rise  <= synced & ~level;
            fall  <= ~synced & level;
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - byte-oriented I2C write-only slave with address match and ACK
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h63,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scl,
    inout  tri                       sda,
    output logic                     ack,
    output logic [I2C_BYTE_BITS-1:0] data
);

    logic   scl_lvl, scl_rise, scl_fall;
    logic   sda_lvl, sda_rise, sda_fall;
    logic   start_det, stop_det;
    state_t state, next_state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] byte_next;
    logic   shift_en, load_data, ack_toggle, drive_low;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst_n(rst_n), .din(scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst_n(rst_n), .din(sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    // Only seven bits are stored; the eighth comes straight from the bus on the last rise.
    assign byte_next = {shift, sda_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (start_det) begin
            next_state = ST_ADDR;
        end else if (stop_det) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise && bit_cnt == LAST_BIT) begin
                    if (byte_next[7:1] == ADDR && byte_next[0] == I2C_RW_WRITE)
                        next_state = ST_ADDR_ACK;
                    else
                        next_state = ST_IGNORE;
                end
                ST_DATA: if (scl_rise && bit_cnt == LAST_BIT) next_state = ST_DATA_ACK;
                ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall && ack) next_state = ST_DATA;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        shift_en   = 1'b0;
        load_data  = 1'b0;
        ack_toggle = 1'b0;
        if (!start_det && !stop_det) begin
            shift_en   = (state == ST_ADDR || state == ST_DATA) && scl_rise;
            load_data  = (state == ST_DATA) && scl_rise && bit_cnt == LAST_BIT;
            ack_toggle = (state == ST_ADDR_ACK || state == ST_DATA_ACK) && scl_fall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
            data    <= '0;
        end else if (start_det || stop_det) begin
            ack     <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            if (ack_toggle) ack <= ~ack;
            if (shift_en) begin
                shift   <= byte_next[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (load_data) data <= byte_next;
        end
    end

    assign drive_low = ack;
    assign sda       = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - randomized self-checking bench for i2c_slave against a byte-level bus model
module tb_i2c_slave;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scl_m   = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic       ack;
    logic [7:0] data;

    int         n_checks  = 0;
    int         n_fails   = 0;
    int         ack_rises = 0;
    int         exp_rises = 0;
    logic [7:0] exp_data  = 8'h00;
    bit         addressed = 1'b0;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h63), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda), .ack(ack), .data(data)
    );

    always @(posedge ack) ack_rises++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_clock(input logic b);
        tick(2); sda_low = !b;
        tick(3); scl_m = 1'b1;
        tick(2);
        check("sda_bit", 32'(sda), 32'(b));
        check("ack_in_bit", 32'(ack), 32'(0));
        tick(3); scl_m = 1'b0;
    endtask

    task automatic ack_slot(input bit exp);
        sda_low = 1'b0;
        tick(3); check("ack_early", 32'(ack), 32'(0));
        tick(1); check("ack_latency", 32'(ack), 32'(exp));
        tick(1); scl_m = 1'b1;
        tick(2);
        check("ack_sda", 32'(sda), 32'(!exp));
        check("ack_high", 32'(ack), 32'(exp));
        tick(3); scl_m = 1'b0;
        tick(3); check("ack_hold", 32'(ack), 32'(exp));
        tick(1); check("ack_release", 32'(ack), 32'(0));
        if (exp) exp_rises++;
    endtask

    task automatic start_cond();
        sda_low = 1'b0;
        tick(2); scl_m = 1'b1;
        tick(3); sda_low = 1'b1;
        tick(3); scl_m = 1'b0;
        addressed = 1'b0;
    endtask

    task automatic stop_cond();
        tick(2); sda_low = 1'b1;
        tick(2); scl_m = 1'b1;
        tick(3); sda_low = 1'b0;
        tick(4);
        addressed = 1'b0;
        check("data_after_stop", 32'(data), 32'(exp_data));
    endtask

    task automatic send_addr(input logic [7:0] a);
        for (int i = 7; i >= 0; i--) bit_clock(a[i]);
        addressed = (a[7:1] == 7'h63) && (a[0] == 1'b0);
        ack_slot(addressed);
    endtask

    task automatic send_data(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_clock(b[i]);
        ack_slot(addressed);
        if (addressed) exp_data = b;
        check("data", 32'(data), 32'(exp_data));
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) bit_clock(b[7-i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("reset_ack", 32'(ack), 32'(0));
        check("reset_data", 32'(data), 32'(0));
        check("reset_sda", 32'(sda), 32'(1));
        rst_n = 1'b1;
        tick(4);

        start_cond(); send_addr(8'hC4); send_data(8'h3C); stop_cond();
        start_cond(); send_addr(8'hC7); send_data(8'h99); send_data(8'h12); stop_cond();
        start_cond(); send_addr(8'hC6); send_data(8'h53); stop_cond();

        start_cond(); send_addr(8'hC6); send_partial(8'hF0, 4); stop_cond();
        send_data(8'h0F);

        start_cond(); send_addr(8'hC6); send_data(8'h5A);
        start_cond(); send_addr(8'hC6); send_data(8'hA5); stop_cond();

        // Reset while the slave is holding SDA low in a data ACK slot.
        start_cond(); send_addr(8'hC6);
        sda_low = 1'b0;
        send_partial(8'h77, 8);
        tick(4);
        check("ack_before_reset", 32'(ack), 32'(1));
        exp_rises++;
        #1 rst_n = 1'b0;
        #1;
        check("reset_async_ack", 32'(ack), 32'(0));
        check("reset_async_sda", 32'(sda), 32'(1));
        check("reset_async_data", 32'(data), 32'(0));
        exp_data  = 8'h00;
        addressed = 1'b0;
        tick(2); rst_n = 1'b1;
        tick(2);
        start_cond(); send_addr(8'hC6); send_data(8'h3E); stop_cond();

        for (int t = 0; t < 10; t++) begin
            logic [7:0] a;
            a = ($urandom % 2 == 0) ? 8'hC6 : 8'($urandom_range(0, 255));
            start_cond();
            send_addr(a);
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) send_data(8'($urandom));
            if ($urandom % 3 == 0) send_partial(8'($urandom), int'($urandom_range(1, 7)));
            stop_cond();
        end

        check("ack_rise_count", 32'(ack_rises), 32'(exp_rises));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Byte-oriented I2C slave receiver (write-only target). It oversamples the bus SCL/SDA lines on a fast system clock and detects START/STOP conditions. It matches a 7-bit address, shifts in data bytes MSB-first and acknowledges each accepted byte by pulling SDA low. It sits at the chip boundary between the open-drain I2C pads and the register/command logic that consumes `data`.

## Interface
- `ADDR`, default 7'h63: own 7-bit slave address.
- `SYNC_STAGES`, default 2: synchronizer depth on SCL and SDA inputs.
- `clk` input 1: system clock; frequency ≥ 8× SCL frequency.
- `rst_n` input 1: reset, asynchronous, active-low.
- `scl` input 1: bus clock from the master.
- `sda` inout 1: bus data, open-drain. The block only drives 0 or Z, never 1.
- `ack` output 1: high exactly while the block drives SDA low in an ACK slot.
- `data` output 8: last accepted data byte; holds until the next one is accepted.

## Operation
- SCL and SDA pass through `SYNC_STAGES` flops, then a 1-flop edge detector. All decisions use the synchronized values.
- START: SDA falls while SCL high. Accepted in any state, so a repeated START is legal; it aborts the current byte. Go to ADDR, clear bit counter and shift register.
- STOP: SDA rises while SCL high. From any state go to IDLE and release SDA.
- Sampling:
  - SDA is shifted into an 8-bit register MSB-first on each synchronized SCL rising edge.
  - The bit counter counts 0..7.
  - SDA drive changes only on SCL falling edges.
- States:
  - IDLE: wait for START.
  - ADDR: receive 8 bits. After the 8th rise:
    - If shift[7:1]==ADDR and shift[0]==0 (write), go to ADDR_ACK.
    - Otherwise go to IGNORE.
  - ADDR_ACK: on the next SCL fall, drive SDA low and set `ack`=1. On the following fall (after the 9th rise), release SDA, clear `ack`, go to DATA.
  - DATA: receive 8 bits. On the 8th rise, load `data` with the shift register, then go to DATA_ACK.
  - DATA_ACK: identical to ADDR_ACK, then return to DATA for the next byte.
  - IGNORE: never drive SDA. Wait for START or STOP. This covers address mismatch and read requests (R/W=1, which are NACKed).
- SDA is never driven outside the ACK slot, and never while SCL is high except inside that slot.

## Timing
- Reset values: state IDLE, `data`=8'h00, `ack`=0, SDA released (Z), counters 0.
- Reset asserted mid-transfer, including mid-ACK: SDA releases and `ack` drops immediately (asynchronous), with no clock edge needed.
- Input latency: SYNC_STAGES+1 clk from a pin change to the detected edge.
- `data` updates SYNC_STAGES+2 clk after the 8th SCL rising edge of a data byte.
- ACK is asserted SYNC_STAGES+2 clk after the SCL falling edge that ends bit 8. It is released the same delay after the SCL falling edge that ends the 9th clock.
- A START and an SCL edge are never detected in the same clk. If both appear, START/STOP wins.
- A STOP or START mid-byte discards the partial byte; `data` is unchanged.

## Structure
- Package `i2c_pkg`:
  - state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE);
  - constants `I2C_RW_WRITE`=0 and `I2C_BYTE_BITS`=8.
- Sub-module `i2c_sync_edge`: one instance each for SCL and SDA. It provides the synchronizer, registered level, and rise/fall pulses.
- Top level holds the FSM, bit counter, shift register, data register and the open-drain driver (`sda = drive_low ? 1'b0 : 1'bz`).

## Test plan
- Write transfer with SCL period 10 and clk ≥ 8×: START, address byte 0xC6 (bits 1,1,0,0,0,1,1,0), ACK slot, byte 0x53, ACK slot. Required: `ack` high only during both 9th clocks, SDA reads 0 there; `data`=0x53 after the second byte.
- Address 0x62+W (byte 0xC4): no ACK; SDA stays Z for the following byte; `data` unchanged (0x00).
- Read request 0xC7: NACK; block stays in IGNORE until STOP; `ack` never rises.
- After 0xC6 ACK, send 4 bits of a data byte, then STOP. Required: state IDLE, `data` keeps its previous value, SDA released.
- Repeated START after the data ACK, then 0xC6 plus byte 0xA5: both bytes ACKed, `data`=0xA5.
- Assert `rst_n`=0 while the block drives ACK: SDA is Z and `ack`=0 within the same time step; `data`=0x00; the next START is handled normally.
